// File: rtl/operand_fetch_pkg.sv
// Shared CPU definitions: source-operand modes, ALU-op constants and the
// operand-fetch state encoding.
package cpu_defs;

   // Source operand addressing modes as delivered by the decoder
   localparam logic [1:0] SRC_IMM = 2'd0;
   localparam logic [1:0] SRC_REG = 2'd1;
   localparam logic [1:0] SRC_DIR = 2'd2;
   localparam logic [1:0] SRC_IND = 2'd3;

   // ALU operation codes used by execute; NO_ALU marks simple-op instructions
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;
   localparam logic [3:0] ALU_XOR = 4'h4;
   localparam logic [3:0] NO_ALU  = 4'hF;

   // Operand-fetch sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PTR  = 3'd1,
      ST_PTRW = 3'd2,
      ST_ADDR = 3'd3,
      ST_DATA = 3'd4,
      ST_HOLD = 3'd5
   } state_t;

endpackage

// File: rtl/operand_fetch_addr_gen.sv
// Combinational internal-RAM address for the first read of an instruction:
// Rn location for REG, op1 for DIR, Ri pointer location for IND.
module operand_addr_gen
   import cpu_defs::*;
(
   input  logic [1:0] src_mode,
   input  logic [2:0] reg_sel,
   input  logic [7:0] op1,
   input  logic [1:0] bank,
   output logic [7:0] addr
);

   // Select the register-bank slot, the direct address or the Ri slot
   always_comb begin
      // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
      addr = 8'h00;
      case (src_mode)
         SRC_REG: addr = {3'b000, bank, reg_sel};
         SRC_DIR: addr = op1;
         SRC_IND: addr = {3'b000, bank, 2'b00, reg_sel[0]};
         default: addr = 8'h00;
      endcase
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: accepts one decoded instruction, resolves the source
// operand over the internal RAM read bus and holds it for execute.
module operand_fetch
   import cpu_defs::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       dec_valid,
   output logic       dec_ready,
   input  logic [7:0] instruction,
   input  logic [7:0] op1,
   input  logic [1:0] src_mode,
   input  logic [3:0] alu_op_in,
   input  logic [7:0] acc,
   input  logic [7:0] psw,
   output logic [7:0] ram_addr,
   output logic       ram_rd,
   input  logic [7:0] ram_rdata,
   output logic       ex_valid,
   input  logic       ex_ready,
   output logic [7:0] a_data,
   output logic [7:0] b_data,
   output logic [2:0] bit_location,
   output logic [3:0] alu_op,
   output logic [7:0] instr_out
);

   state_t     state_q, state_d;
   logic       dec_ready_q, dec_ready_d;
   logic       ex_valid_q, ex_valid_d;
   logic       ram_rd_q, ram_rd_d;
   logic [7:0] ram_addr_q, ram_addr_d;
   logic [7:0] a_data_q, a_data_d;
   logic [7:0] b_data_q, b_data_d;
   logic [2:0] bit_loc_q, bit_loc_d;
   logic [3:0] alu_op_q, alu_op_d;
   logic [7:0] instr_q, instr_d;
   logic [7:0] fetch_addr;

   // The first RAM address is only needed on the accept cycle, so it is
   // computed straight from the decoder fields and the live bank bits; later
   // acc/psw changes cannot disturb an in-flight instruction.
   operand_addr_gen u_addr_gen (
      .src_mode (src_mode),
      .reg_sel  (instruction[2:0]),
      .op1      (op1),
      .bank     (psw[4:3]),
      .addr     (fetch_addr)
   );

   // Next-state, operand capture and registered bus/handshake outputs
   always_comb begin
      state_d    = state_q;
      a_data_d   = a_data_q;
      b_data_d   = b_data_q;
      bit_loc_d  = bit_loc_q;
      alu_op_d   = alu_op_q;
      instr_d    = instr_q;
      ram_addr_d = 8'h00;

      case (state_q)
         ST_IDLE: begin
            if (dec_valid) begin
               a_data_d  = acc;
               instr_d   = instruction;
               alu_op_d  = alu_op_in;
               bit_loc_d = op1[2:0];
               case (src_mode)
                  SRC_IMM: begin
                     b_data_d = op1;
                     state_d  = ST_HOLD;
                  end
                  SRC_IND: begin
                     ram_addr_d = fetch_addr;
                     state_d    = ST_PTR;
                  end
                  default: begin
                     ram_addr_d = fetch_addr;
                     state_d    = ST_ADDR;
                  end
               endcase
            end
         end
         ST_PTR:  state_d = ST_PTRW;
         ST_PTRW: begin
            // The returned Ri value lands directly in the address register,
            // which acts as the pointer register for the following read.
            ram_addr_d = ram_rdata;
            state_d    = ST_ADDR;
         end
         ST_ADDR: state_d = ST_DATA;
         ST_DATA: begin
            b_data_d = ram_rdata;
            state_d  = ST_HOLD;
         end
         ST_HOLD: begin
            if (ex_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they leave flops cleanly
      ram_rd_d    = (state_d == ST_PTR) || (state_d == ST_ADDR);
      ex_valid_d  = (state_d == ST_HOLD);
      dec_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         dec_ready_q <= 1'b1;
         ex_valid_q  <= 1'b0;
         ram_rd_q    <= 1'b0;
         ram_addr_q  <= 8'h00;
         a_data_q    <= 8'h00;
         b_data_q    <= 8'h00;
         bit_loc_q   <= 3'd0;
         alu_op_q    <= 4'h0;
         instr_q     <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         dec_ready_q <= dec_ready_d;
         ex_valid_q  <= ex_valid_d;
         ram_rd_q    <= ram_rd_d;
         ram_addr_q  <= ram_addr_d;
         a_data_q    <= a_data_d;
         b_data_q    <= b_data_d;
         bit_loc_q   <= bit_loc_d;
         alu_op_q    <= alu_op_d;
         instr_q     <= instr_d;
      end
   end

   assign dec_ready    = dec_ready_q;
   assign ex_valid     = ex_valid_q;
   assign ram_rd       = ram_rd_q;
   assign ram_addr     = ram_addr_q;
   assign a_data       = a_data_q;
   assign b_data       = b_data_q;
   assign bit_location = bit_loc_q;
   assign alu_op       = alu_op_q;
   assign instr_out    = instr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// transactions against a behavioural operand/latency model and a RAM model.
module tb_operand_fetch;
   import cpu_defs::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       dec_valid;
   logic       dec_ready;
   logic [7:0] instruction;
   logic [7:0] op1;
   logic [1:0] src_mode;
   logic [3:0] alu_op_in;
   logic [7:0] acc;
   logic [7:0] psw;
   logic [7:0] ram_addr;
   logic       ram_rd;
   logic [7:0] ram_rdata = 8'h00;
   logic       ex_valid;
   logic       ex_ready;
   logic [7:0] a_data;
   logic [7:0] b_data;
   logic [2:0] bit_location;
   logic [3:0] alu_op;
   logic [7:0] instr_out;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mem [0:255];

   operand_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .instruction  (instruction),
      .op1          (op1),
      .src_mode     (src_mode),
      .alu_op_in    (alu_op_in),
      .acc          (acc),
      .psw          (psw),
      .ram_addr     (ram_addr),
      .ram_rd       (ram_rd),
      .ram_rdata    (ram_rdata),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .a_data       (a_data),
      .b_data       (b_data),
      .bit_location (bit_location),
      .alu_op       (alu_op),
      .instr_out    (instr_out)
   );

   always #5 clk = ~clk;

   // Single-port RAM: data appears the cycle after the read strobe
   always @(posedge clk) if (ram_rd) ram_rdata <= mem[ram_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Drive one instruction and verify reads, latency, operands and handshake
   task automatic do_txn(input logic [1:0] mode, input logic [7:0] ins, input logic [7:0] o1,
                         input logic [7:0] ac, input logic [7:0] ps, input logic [3:0] alu,
                         input int stall, input bit ready_early);
      int         bank, exp_lat, lat, first;
      logic [7:0] exp_b;
      logic [7:0] exp_reads [$];
      logic [7:0] got_reads [$];
      bit         seen;

      // Reference model: operand value, read sequence and latency by mode
      bank = int'(ps[4:3]);
      case (mode)
         SRC_IMM: begin exp_b = o1; exp_lat = 1; end
         SRC_REG: begin
            first = bank * 8 + int'(ins % 8);
            exp_reads.push_back(8'(first));
            exp_b = mem[first]; exp_lat = 3;
         end
         SRC_DIR: begin
            exp_reads.push_back(o1);
            exp_b = mem[o1]; exp_lat = 3;
         end
         default: begin
            first = bank * 8 + int'(ins % 2);
            exp_reads.push_back(8'(first));
            exp_reads.push_back(mem[first]);
            exp_b = mem[mem[first]]; exp_lat = 5;
         end
      endcase

      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
         @(negedge clk);
         seen = dec_ready;
      end
      check("dec_ready_wait", 32'(seen), 32'd1);

      dec_valid = 1'b1; instruction = ins; op1 = o1; src_mode = mode;
      acc = ac; psw = ps; alu_op_in = alu; ex_ready = ready_early;
      @(posedge clk);

      lat = 0; seen = 1'b0;
      for (int c = 1; c <= 12 && !seen; c++) begin
         @(negedge clk);
         if (ram_rd) got_reads.push_back(ram_addr);
         else check("addr_zero_idle", 32'(ram_addr), 32'd0);
         check("busy_dec_ready", 32'(dec_ready), 32'd0);
         if (ex_valid) begin lat = c; seen = 1'b1; end
         // Busy-time noise that must be ignored
         dec_valid = 1'b1; instruction = 8'($urandom); op1 = 8'($urandom);
         src_mode = 2'($urandom); acc = 8'($urandom); psw = 8'($urandom);
         alu_op_in = 4'($urandom);
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("n_reads", 32'(got_reads.size()), 32'(exp_reads.size()));
      for (int i = 0; i < exp_reads.size(); i++)
         if (i < got_reads.size()) check("read_addr", 32'(got_reads[i]), 32'(exp_reads[i]));
      check("a_data", 32'(a_data), 32'(ac));
      check("b_data", 32'(b_data), 32'(exp_b));
      check("bit_location", 32'(bit_location), 32'(o1 % 8));
      check("alu_op", 32'(alu_op), 32'(alu));
      check("instr_out", 32'(instr_out), 32'(ins));

      if (!ready_early) begin
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_ex_valid", 32'(ex_valid), 32'd1);
            check("hold_dec_ready", 32'(dec_ready), 32'd0);
            check("hold_a_data", 32'(a_data), 32'(ac));
            check("hold_b_data", 32'(b_data), 32'(exp_b));
            check("hold_instr", 32'(instr_out), 32'(ins));
            dec_valid = 1'b1; instruction = 8'($urandom); src_mode = 2'($urandom);
         end
         ex_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      ex_ready = 1'b0; dec_valid = 1'b0;
      check("post_ex_valid", 32'(ex_valid), 32'd0);
      check("post_dec_ready", 32'(dec_ready), 32'd1);
      check("post_ram_rd", 32'(ram_rd), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      rst = 1'b1; dec_valid = 1'b0; instruction = 8'h00; op1 = 8'h00;
      src_mode = SRC_IMM; alu_op_in = 4'h0; acc = 8'h00; psw = 8'h00; ex_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_dec_ready", 32'(dec_ready), 32'd1);
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_ram_rd", 32'(ram_rd), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_a_data", 32'(a_data), 32'd0);
      check("rst_b_data", 32'(b_data), 32'd0);
      check("rst_instr", 32'(instr_out), 32'd0);

      // Immediate ADD
      do_txn(SRC_IMM, 8'h24, 8'h5A, 8'h11, 8'h00, ALU_ADD, 0, 1'b0);
      // Register R3 in bank 2
      mem[8'h13] = 8'h77;
      do_txn(SRC_REG, 8'h2B, 8'h00, 8'h22, 8'h10, ALU_ADD, 0, 1'b0);
      // Indirect @R1 in bank 1
      mem[8'h09] = 8'h40; mem[8'h40] = 8'hC3;
      do_txn(SRC_IND, 8'h27, 8'h00, 8'h33, 8'h08, ALU_ADD, 0, 1'b0);
      // Backpressure in HOLD, SFR-range direct address
      do_txn(SRC_DIR, 8'h25, 8'hE0, 8'h44, 8'h00, ALU_XOR, 4, 1'b0);
      // ex_ready asserted early has no effect before HOLD
      do_txn(SRC_IND, 8'h26, 8'h00, 8'h5C, 8'h18, ALU_OR, 0, 1'b1);
      // Simple op: SWAP with no ALU
      do_txn(SRC_IMM, 8'hC4, 8'h00, 8'hA5, 8'h00, NO_ALU, 0, 1'b0);

      // Reset while waiting for the pointer read
      @(negedge clk);
      dec_valid = 1'b1; instruction = 8'h27; op1 = 8'h00; src_mode = SRC_IND;
      psw = 8'h08; acc = 8'h55; alu_op_in = ALU_ADD;
      @(posedge clk);
      @(negedge clk);
      dec_valid = 1'b0;
      check("mid_ptr_rd", 32'(ram_rd), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
      check("mid_rst_ram_rd", 32'(ram_rd), 32'd0);
      check("mid_rst_dec_ready", 32'(dec_ready), 32'd1);
      check("mid_rst_a_data", 32'(a_data), 32'd0);
      @(negedge clk);
      check("mid_rst_no_read", 32'(ram_rd), 32'd0);
      mem[8'h30] = 8'h9E;
      do_txn(SRC_DIR, 8'hE5, 8'h30, 8'h66, 8'h00, ALU_ADD, 0, 1'b0);

      // Randomized traffic
      for (int t = 0; t < 40; t++)
         do_txn(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
